// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with guard blanking
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank_digit;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Walk digits from the top so the leading-zero flag accumulates downward.
    always_comb begin
        nib         = 4'h0;
        dp_bit      = 1'b0;
        blank_digit = 1'b0;
        an_next     = '1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic lz;
            lz = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                lz = lz && (shadow_val[4*i +: 4] == 4'h0) && !shadow_dp[i];
                if (idx == IW'(i)) begin
                    nib         = shadow_val[4*i +: 4];
                    dp_bit      = shadow_dp[i];
                    an_next[i]  = 1'b0;
                    blank_digit = lz && (i != 0);
                end
            end
        end
`else
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib        = shadow_val[4*i +: 4];
                dp_bit     = shadow_dp[i];
                an_next[i] = 1'b0;
            end
        end
`endif
        if (presc < GUARD_END) begin
            seg_next = 8'hFF;
            an_next  = '1;
        end else if (blank_digit) begin
            seg_next = 8'hFF;
        end else begin
            seg_next = {~dp_bit, decode(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            seg        <= 8'hFF;
            an         <= '1;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Expectations switch with SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .dp    (dp),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_seg, input logic [3:0] exp_an);
        checks++;
        assert (seg === exp_seg && an === exp_an) else begin
            errors++;
            $error("FAIL %s: seg=%h an=%h expected seg=%h an=%h", tag, seg, an, exp_seg, exp_an);
        end
    endtask

    // One blank cycle then three visible cycles of the given digit.
    task automatic check_slot(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        tick();
        check({tag, "_blank"}, 8'hFF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check(tag, exp_seg, exp_an);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset", 8'hFF, 4'hF);
        end
        rst = 1'b0; load = 1'b0;
        check_slot("post_reset_d0", 4'hE, 8'hC0);

        value = 16'h12AF; dp = 4'h0; load = 1'b1;
        check_slot("scan_d1", 4'hD, 8'h88);
        check_slot("scan_d2", 4'hB, 8'hA4);
        check_slot("scan_d3", 4'h7, 8'hF9);
        check_slot("scan_d0", 4'hE, 8'h8E);
        check_slot("scan_wrap_d1", 4'hD, 8'h88);
        check_slot("scan_d2b", 4'hB, 8'hA4);
        check_slot("scan_d3b", 4'h7, 8'hF9);

        for (int c = 0; c < 16; c++) begin
            value = 16'(c); load = 1'b1;
            check_slot($sformatf("code_%0h", c), 4'hE, {1'b1, tab[c]});
            load = 1'b0;
            check_slot("code_d1", 4'hD, LZ);
            check_slot("code_d2", 4'hB, LZ);
            check_slot("code_d3", 4'h7, LZ);
        end

        value = 16'h0000; dp = 4'b0100; load = 1'b1;
        check_slot("dp_d0", 4'hE, 8'hC0);
        load = 1'b0;
        check_slot("dp_d1", 4'hD, 8'hC0);
        check_slot("dp_d2", 4'hB, 8'h40);
        check_slot("dp_d3", 4'h7, LZ);

        dp = 4'h0; load = 1'b1;
        tick();
        check("mid_blank", 8'hFF, 4'hF);
        load = 1'b0;
        tick();
        check("mid_vis1", 8'hC0, 4'hE);
        value = 16'h0005; load = 1'b1;
        tick();
        check("mid_vis2_old", 8'hC0, 4'hE);
        load = 1'b0;
        tick();
        check("mid_vis3_new", 8'h92, 4'hE);
        check_slot("mid_d1", 4'hD, LZ);
        check_slot("mid_d2", 4'hB, LZ);
        check_slot("mid_d3", 4'h7, LZ);

        value = 16'h0030; load = 1'b1;
        check_slot("lz_d0", 4'hE, 8'hC0);
        load = 1'b0;
        check_slot("lz_d1", 4'hD, 8'hB0);
        check_slot("lz_d2", 4'hB, LZ);
        check_slot("lz_d3", 4'h7, LZ);

        tick();
        check("pre_rst_blank", 8'hFF, 4'hF);
        tick();
        check("pre_rst_vis", 8'hC0, 4'hE);
        rst = 1'b1;
        tick();
        check("mid_reset", 8'hFF, 4'hF);
        rst = 1'b0;
        check_slot("restart_d0", 4'hE, 8'hC0);
        check_slot("restart_d1", 4'hD, LZ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
